// File: rtl/fir_coef_loader.sv
// Coefficient table that streams its contents, highest index first, into a FIR shift chain.
// Optional readback port enabled by defining FIR_COEF_READBACK_EN.
module fir_coef_loader #(
   parameter int MAX_LEN = 64,
   parameter int COEF_W  = 25,
   localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AW-1:0]     wr_addr,
   input  logic [COEF_W-1:0] wr_data,
   input  logic              wr_en,
   input  logic              start,
   input  logic [31:0]       filt_len,
   output logic [COEF_W-1:0] cfg_din,
   output logic              cfg_ce,
   output logic              busy,
   output logic              done,
   output logic              err
`ifdef FIR_COEF_READBACK_EN
   ,
   input  logic [AW-1:0]     rd_addr,
   output logic [COEF_W-1:0] rd_data
`endif
);

   typedef enum logic [1:0] {IDLE, PRIME, LOAD, FINISH} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic              last_q, last_d;
   logic [COEF_W-1:0] cfg_din_q, cfg_din_d;
   logic              err_q, err_d;
   logic              len_ok;
   logic [COEF_W-1:0] coef_mem [MAX_LEN];

   assign len_ok = (filt_len != 32'd0) && (filt_len <= 32'(MAX_LEN));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_q    <= 1'b0;
         cfg_din_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         cfg_din_q <= cfg_din_d;
         err_q     <= err_d;
      end
   end

   // Table contents survive reset on purpose so a reload needs no rewrite.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && wr_en) begin
         coef_mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && len_ok) state_d = PRIME;
         PRIME:   state_d = LOAD;
         LOAD:    if (last_q) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // cfg_din_q doubles as the registered read port; it freezes once entry 0 is fetched.
   always_comb begin
      cnt_d     = cnt_q;
      last_d    = last_q;
      cfg_din_d = cfg_din_q;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            last_d = 1'b0;
            if (start) begin
               if (len_ok) cnt_d = AW'(filt_len - 32'd1);
               else        err_d = 1'b1;
            end
         end
         PRIME, LOAD: begin
            if (state_q == PRIME || !last_q) begin
               cfg_din_d = coef_mem[cnt_q];
               last_d    = (cnt_q == '0);
               if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      cfg_din = cfg_din_q;
      cfg_ce  = (state_q == LOAD);
      busy    = (state_q != IDLE);
      done    = (state_q == FINISH);
      err     = err_q;
   end

`ifdef FIR_COEF_READBACK_EN
   logic [COEF_W-1:0] rd_data_q, rd_data_d;

   assign rd_data_d = coef_mem[rd_addr];

   always_ff @(posedge clk) begin
      if (reset) rd_data_q <= '0;
      else       rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;
`endif

endmodule
